ram_stream_reader: RTL and testbench
====================================

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, RAM data width.
REQ-002 SHALL have parameter AWIDTH, default 13, RAM address width.
REQ-003 SHALL have parameter MEM_SIZE, default 3072, RAM depth in words.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port cmd_base, input, AWIDTH, first word address.
REQ-008 SHALL have port cmd_len, input, AWIDTH+1, word count, range 0..MEM_SIZE.
REQ-009 SHALL have port cmd_valid, input, 1, command offered.
REQ-010 SHALL have port cmd_ready, output, 1, command accepted when high with cmd_valid.
REQ-011 SHALL have port ram_addr0, output, AWIDTH, RAM port-0 address.
REQ-012 SHALL have port ram_ce0, output, 1, RAM port-0 clock enable; it also advances the RAM two-stage output pipeline.
REQ-013 SHALL have port ram_we0, output, 1, RAM write enable, constant 0.
REQ-014 SHALL have port ram_q0, input, DWIDTH, RAM port-0 read data; valid two ce0-qualified edges after its address.
REQ-015 SHALL have port data_out, output, DWIDTH, streamed word, driven equal to ram_q0.
REQ-016 SHALL have port data_out_valid, output, 1, data_out valid.
REQ-017 SHALL have port data_out_ready, input, 1, consumer accepts the word.
REQ-018 SHALL have port data_out_last, output, 1, final word of the command.
REQ-019 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-020 SHALL implement the states IDLE, READ and DRAIN.
REQ-021 SHALL assert cmd_ready only in IDLE.
REQ-022 SHALL, on acceptance, latch the address as cmd_base and the remaining count as cmd_len, and enter READ, or DRAIN if cmd_len=0.
REQ-023 SHALL define advance = !s2_valid || data_out_ready, where s1_valid and s2_valid are the valid-tag pipeline stages.
REQ-024 SHALL drive ram_ce0 = advance in READ and DRAIN, and ram_ce0 = 0 in IDLE.
REQ-025 SHALL, in READ, on each edge with advance=1, shift s1_valid to s2_valid, set s1_valid=1, increment the address and decrement the remaining count.
REQ-026 SHALL wrap the address from MEM_SIZE-1 to 0.
REQ-027 SHALL carry a last tag alongside s1/s2, set on the issue where the remaining count is 1.
REQ-028 SHALL leave READ for DRAIN on the edge that issues the last address.
REQ-029 SHALL, in DRAIN, on advance shift s1 to s2 with s1 loaded 0, and return to IDLE when s1_valid=0, s2_valid=0 and no issue is pending.
REQ-030 SHALL drive data_out_valid = s2_valid and data_out_last = s2_last.
REQ-031 SHALL hold data_out, data_out_valid and data_out_last stable while data_out_valid=1 and data_out_ready=0; the RAM pipeline is frozen because ce0=0.
REQ-032 SHALL give a first-word latency of 3 cycles from the command-accept edge to data_out_valid, with no stall.
REQ-033 SHALL sustain 1 word per cycle while data_out_ready=1.
REQ-034 SHALL ignore cmd_valid outside IDLE; a command presented during DRAIN waits.
REQ-035 SHALL treat a cmd_len greater than MEM_SIZE as undefined; an assertion flags it.

Reset
REQ-036 SHALL, on rst low, asynchronously force state IDLE, s1_valid, s2_valid, s1_last and s2_last to 0, the address and count to 0, ram_ce0=0 and busy=0.
REQ-037 SHALL discard any command in progress when reset is asserted mid-operation, emitting no further words after deassertion.
REQ-038 SHALL assert cmd_ready on the first edge after reset deassertion.

Structure
REQ-039 SHALL take the state enum typedef from the shared package ram_stream_pkg.
REQ-040 SHALL contain no sub-module; it connects directly to ram_block port 0, with port 1 tied off by the integrator.

Verification
REQ-041 SHALL cover: RAM preloaded with mem[i]=i[7:0], cmd base=10 len=4, ready=1 -> data 10,11,12,13 on cycles 3..6, last on 13, then busy drops.
REQ-042 SHALL cover: base=3070 len=4 -> data mem[3070], mem[3071], mem[0], mem[1].
REQ-043 SHALL cover: len=0 -> no data_out_valid, busy high exactly one cycle, cmd_ready back the next cycle.
REQ-044 SHALL cover: base=0 len=8, data_out_ready toggled 1,0,0,1,... -> 8 words in order, no duplicates or drops, held stable when stalled.
REQ-045 SHALL cover: rst pulsed low after 2 of 6 words -> outputs 0 immediately, then a new cmd base=100 len=2 gives 100,101.
REQ-046 SHALL cover: a second cmd_valid held during DRAIN -> accepted only after the last word, with back-to-back gap of at most 2 cycles.

Source files
------------

// File: rtl/ram_stream_pkg.sv
// Shared definitions for the RAM stream reader.
//   rd_state_t : sequencing states of the reader FSM
package ram_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/ram_stream_reader.sv
// Streams a contiguous (wrapping) block of words out of a single-port RAM
// with a two-stage, ce-gated output pipeline, under valid/ready flow control.
//
// States
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for a command, cmd_ready high, RAM disabled
//   ST_READ  | issuing addresses, one per edge whenever the pipeline advances
//   ST_DRAIN | all addresses issued, flushing words still in the pipeline
//
// Ports
//   clk, rst                      : clock, async active-low reset
//   cmd_base/cmd_len/cmd_valid    : command (first address, word count)
//   cmd_ready                     : command accepted when high with cmd_valid
//   ram_addr0/ram_ce0/ram_we0     : RAM port-0 control (read only)
//   ram_q0                        : RAM port-0 read data (2 ce-edges latency)
//   data_out/_valid/_ready/_last  : output word stream
//   busy                          : high whenever not idle
module ram_stream_reader
    import ram_stream_pkg::*;
#(
    parameter int DWIDTH   = 8,
    parameter int AWIDTH   = 13,
    parameter int MEM_SIZE = 3072
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] cmd_base,
    input  logic [AWIDTH:0]   cmd_len,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic [AWIDTH-1:0] ram_addr0,
    output logic              ram_ce0,
    output logic              ram_we0,
    input  logic [DWIDTH-1:0] ram_q0,
    output logic [DWIDTH-1:0] data_out,
    output logic              data_out_valid,
    input  logic              data_out_ready,
    output logic              data_out_last,
    output logic              busy
);

    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(MEM_SIZE - 1);
    localparam logic [AWIDTH:0]   MAX_LEN   = (AWIDTH+1)'(MEM_SIZE);
    localparam logic [AWIDTH:0]   LEN_ONE   = (AWIDTH+1)'(1);

    rd_state_t         state, state_nxt;
    logic [AWIDTH-1:0] addr;
    logic [AWIDTH:0]   remaining;
    logic              s1_valid, s2_valid;
    logic              s1_last, s2_last;
    logic              advance;
    logic              accept;
    logic              issue;
    logic              shift;

    // The valid/last tags travel in lock-step with the RAM's two internal
    // stages, so the pipeline only moves when the output slot is free.
    assign advance = !s2_valid || data_out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        ram_ce0   = 1'b0;
        accept    = 1'b0;
        issue     = 1'b0;
        shift     = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = (cmd_len == '0) ? ST_DRAIN : ST_READ;
                end
            end
            ST_READ: begin
                ram_ce0 = advance;
                if (advance) begin
                    issue = 1'b1;
                    shift = 1'b1;
                    if (remaining == LEN_ONE) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                ram_ce0 = advance;
                shift   = advance;
                if (!s1_valid && !s2_valid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr      <= '0;
            remaining <= '0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s2_last   <= 1'b0;
        end else begin
            if (accept) begin
                addr      <= cmd_base;
                remaining <= cmd_len;
            end else if (issue) begin
                addr      <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            if (shift) begin
                s2_valid <= s1_valid;
                s2_last  <= s1_last;
                s1_valid <= issue;
                s1_last  <= issue && (remaining == LEN_ONE);
            end
        end
    end

    assign ram_addr0      = addr;
    assign ram_we0        = 1'b0;
    assign data_out       = ram_q0;
    assign data_out_valid = s2_valid;
    assign data_out_last  = s2_last;
    assign busy           = (state != ST_IDLE);

    // Lengths beyond the RAM depth have no defined meaning.
    a_cmd_len_range : assert property (
        @(posedge clk) disable iff (!rst)
        (cmd_valid && cmd_ready) |-> (cmd_len <= MAX_LEN)
    );

endmodule

// File: tb/tb_ram_stream_reader.sv
module tb_ram_stream_reader;

    localparam int DW = 8;
    localparam int AW = 13;
    localparam int MS = 3072;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] cmd_base = '0;
    logic [AW:0]   cmd_len = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] ram_addr0;
    logic          ram_ce0;
    logic          ram_we0;
    logic [DW-1:0] ram_q0 = '0;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          data_out_ready = 1'b1;
    logic          data_out_last;
    logic          busy;

    ram_stream_reader #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS)) dut (
        .clk(clk), .rst(rst),
        .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .ram_addr0(ram_addr0), .ram_ce0(ram_ce0), .ram_we0(ram_we0), .ram_q0(ram_q0),
        .data_out(data_out), .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready), .data_out_last(data_out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM behavioural model: two internal stages, both gated by ce0.
    logic [DW-1:0] mem [MS];
    logic [DW-1:0] ram_p1 = '0;
    always @(posedge clk) begin
        if (ram_ce0) begin
            ram_p1 <= mem[ram_addr0];
            ram_q0 <= ram_p1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_acc = 0;
    int acc_edge = 0;
    int last_hs_edge = 0;
    logic [8:0] exp_q[$];
    int obs[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stream model: every accepted command expands to the list of words it
    // must produce; the DUT output is compared against the head each cycle.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("we0_zero", int'(ram_we0), 0);
            chk("ready_vs_busy", int'(cmd_ready), int'(!busy));
            if (!busy) chk("ce0_idle", int'(ram_ce0), 0);
            if (cmd_valid && cmd_ready) begin
                for (int i = 0; i < int'(cmd_len); i++)
                    exp_q.push_back({(i == int'(cmd_len) - 1), mem[(int'(cmd_base) + i) % MS]});
                n_acc++;
                acc_edge = cyc + 1;
            end
            if (prev_stall) begin
                chk("stall_valid", int'(data_out_valid), 1);
                chk("stall_data", int'(data_out), int'(prev_data));
                chk("stall_last", int'(data_out_last), int'(prev_last));
            end
            if (data_out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL spurious_word: got data %0d expected no word (t=%0t)", data_out, $time);
                end else begin
                    chk("stream_data", int'(data_out), int'(exp_q[0][7:0]));
                    chk("stream_last", int'(data_out_last), int'(exp_q[0][8]));
                    if (data_out_ready) begin
                        obs.push_back(int'(data_out));
                        if (exp_q[0][8]) last_hs_edge = cyc + 1;
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_stall = data_out_valid && !data_out_ready;
            prev_data  = data_out;
            prev_last  = data_out_last;
        end
    end

    task automatic send_cmd(input int base, input int len);
        int start;
        bit ok;
        start = n_acc;
        ok = 1'b0;
        @(posedge clk); #1;
        cmd_base  = AW'(base);
        cmd_len   = (AW+1)'(len);
        cmd_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); #1;
            if (n_acc != start) ok = 1'b1;
        end
        chk("cmd_accept", int'(ok), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk); #1;
            if (!busy && exp_q.size() == 0) ok = 1'b1;
        end
        chk(name, int'(ok), 1);
    endtask

    int vv[10], dd[10], ll[10], bb[10];
    int gap;
    bit ok;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        for (int i = 0; i < MS; i++) mem[i] = DW'(i);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(data_out_valid), 0);
        chk("rst_last", int'(data_out_last), 0);
        chk("rst_ce0", int'(ram_ce0), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", int'(cmd_ready), 1);

        // base=10 len=4, consumer always ready
        obs.delete();
        send_cmd(10, 4);
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            vv[n] = int'(data_out_valid);
            dd[n] = int'(data_out);
            ll[n] = int'(data_out_last);
            bb[n] = int'(busy);
        end
        chk("t1_c2_valid", vv[2], 0);
        chk("t1_c3_valid", vv[3], 1);
        chk("t1_c3_data", dd[3], 10);
        chk("t1_c4_data", dd[4], 11);
        chk("t1_c5_data", dd[5], 12);
        chk("t1_c5_last", ll[5], 0);
        chk("t1_c6_data", dd[6], 13);
        chk("t1_c6_last", ll[6], 1);
        chk("t1_c7_valid", vv[7], 0);
        chk("t1_c7_busy", bb[7], 1);
        chk("t1_c8_busy", bb[8], 0);
        chk("t1_count", obs.size(), 4);
        wait_idle("t1_idle");

        // Address wrap at the top of the RAM
        obs.delete();
        send_cmd(3070, 4);
        wait_idle("t2_idle");
        chk("t2_count", obs.size(), 4);
        if (obs.size() == 4) begin
            chk("t2_w0", obs[0], 254);
            chk("t2_w1", obs[1], 255);
            chk("t2_w2", obs[2], 0);
            chk("t2_w3", obs[3], 1);
        end

        // Zero-length command
        obs.delete();
        send_cmd(5, 0);
        chk("t3_busy_c1", int'(busy), 1);
        @(posedge clk); #1;
        chk("t3_busy_c2", int'(busy), 0);
        chk("t3_ready_c2", int'(cmd_ready), 1);
        repeat (5) @(posedge clk);
        #1;
        chk("t3_no_words", obs.size(), 0);

        // Back-pressure pattern 1,0,0,1
        obs.delete();
        send_cmd(0, 8);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            data_out_ready = pat[i % 4];
            @(posedge clk); #1;
            if (obs.size() >= 8 && !busy) ok = 1'b1;
        end
        data_out_ready = 1'b1;
        chk("t4_done", int'(ok), 1);
        chk("t4_count", obs.size(), 8);
        for (int k = 0; k < 8 && k < obs.size(); k++) chk("t4_order", obs[k], k);
        wait_idle("t4_idle");

        // Reset in the middle of a command
        obs.delete();
        send_cmd(20, 6);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk); #1;
            if (obs.size() >= 2) ok = 1'b1;
        end
        chk("t5_two_words", int'(ok), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("t5_rst_valid", int'(data_out_valid), 0);
        chk("t5_rst_last", int'(data_out_last), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_ce0", int'(ram_ce0), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_ready_after", int'(cmd_ready), 1);
        repeat (5) @(posedge clk);
        #1;
        chk("t5_no_more", obs.size(), 2);
        obs.delete();
        send_cmd(100, 2);
        wait_idle("t5_idle");
        chk("t5_count", obs.size(), 2);
        if (obs.size() == 2) begin
            chk("t5_w0", obs[0], 100);
            chk("t5_w1", obs[1], 101);
        end

        // Second command held during DRAIN
        obs.delete();
        @(posedge clk); #1;
        cmd_base  = AW'(200);
        cmd_len   = (AW+1)'(3);
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); #1;
            if (n_acc > 0 && acc_edge == cyc + 1) ok = 1'b1;
        end
        chk("t6_accept_a", int'(ok), 1);
        @(posedge clk); #1;
        cmd_base = AW'(300);
        cmd_len  = (AW+1)'(2);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); #1;
            if (acc_edge == cyc + 1) ok = 1'b1;
        end
        chk("t6_accept_b", int'(ok), 1);
        gap = acc_edge - last_hs_edge;
        chk("t6_after_last", int'(gap >= 1), 1);
        chk("t6_gap_le2", int'(gap <= 2), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_idle("t6_idle");
        chk("t6_count", obs.size(), 5);
        if (obs.size() == 5) begin
            chk("t6_w0", obs[0], 200);
            chk("t6_w2", obs[2], 202);
            chk("t6_w3", obs[3], 44);
            chk("t6_w4", obs[4], 45);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
